round_sequencer: RTL and testbench
==================================

# round_sequencer

Frame-synchronous round controller for the main pinball screen. It sequences each ball from idle, through spring arming and launch, live play and ball loss, to level-clear pauses and game over. It drives the freeze (`pause`) and re-seed (`reset_level`, `reset_level_pulse`) controls consumed by the ball, flipper and spring blocks, and owns life, level and score bookkeeping. It sits between the collision detector outputs and the moving-object blocks.

## Interface
Parameters:
- LIVES_INIT, 3: lives loaded at game start; range 1..9.
- LEVEL_MAX, 9: last level; clearing it ends the game as a win.
- RESPAWN_FRAMES, 60: frames frozen after a lost ball.
- CLEAR_FRAMES, 90: frames frozen after a level clear.
- LAUNCH_TIMEOUT_FRAMES, 300: frames in ARM before an automatic launch.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-high reset: 1 = reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- start  in  1  level input; only its rising edge is used.
- launchKey  in  1  level input (spring key); its falling edge launches the ball.
- ballLost  in  1  pulse: ball hit the bottom border.
- goodHit  in  1  pulse: ball hit the scoring obstacle.
- badHit  in  1  pulse: ball hit a penalty obstacle.
- pause  out  1  freezes the moving objects.
- reset_level  out  1  holds the ball, flipper and spring at their start positions.
- reset_level_pulse  out  1  one cycle on each entry to ARM; re-seeds the random number block.
- autoLaunch  out  1  one-cycle pulse when the launch timeout fires.
- life  out  4  lives remaining, 0..9.
- level  out  4  current level, 1..LEVEL_MAX.
- score  out  4  score, saturating at 9.
- gameOver  out  1  high in OVER.
- won  out  1  high in OVER when the game ended by clearing LEVEL_MAX.
- state  out  3  current state encoding, for debug and indications.

## Operation
- States are IDLE, ARM, PLAY, LOST, CLEARED and OVER.
- IDLE:
  - pause=1, reset_level=1.
  - A rising edge of start loads life=LIVES_INIT, level=1, score=0, won=0, then moves to ARM.
- ARM:
  - pause=0, reset_level=1.
  - The frame timer is loaded with LAUNCH_TIMEOUT_FRAMES.
  - A falling edge of launchKey moves to PLAY.
  - If the timer expires, autoLaunch is pulsed and the state moves to PLAY.
- PLAY:
  - pause=0, reset_level=0.
  - ballLost or badHit: life is decremented. If the new life is 0, move to OVER; otherwise load RESPAWN_FRAMES and move to LOST.
  - goodHit (with no loss event in the same cycle): score increments, saturating at 9.
    - If level==LEVEL_MAX, set won=1 and move to OVER.
    - Otherwise increment level, load CLEAR_FRAMES and move to CLEARED.
  - Priority: a loss event beats goodHit in the same cycle. ballLost and badHit together cost one life.
  - Only the first event is accepted. Events arriving outside PLAY are ignored.
- LOST and CLEARED:
  - pause=1, reset_level=1.
  - On timer expiry, move to ARM.
- OVER:
  - pause=1, reset_level=1, gameOver=1.
  - A rising edge of start re-initialises exactly as IDLE does and moves to ARM.
- Frame timer:
  - 9-bit counter that decrements only on startOfFrame.
  - It expires on the startOfFrame at which the count is 0. Dwell time is therefore N+1 frame boundaries after load.
  - A load value of 0 expires on the first startOfFrame.
- Edge detection uses registered copies of start and launchKey. Those copies are also updated during reset, so a key held through reset does not produce an edge.

## Timing
- All state changes and outputs are registered. An input event at cycle t is visible on the outputs at t+1.
- reset_level_pulse and autoLaunch are high for exactly one clk cycle.
- Reset (any cycle, including mid-countdown) forces:
  - state=IDLE, pause=1, reset_level=1.
  - reset_level_pulse=0, autoLaunch=0.
  - life=LIVES_INIT, level=1, score=0, gameOver=0, won=0, timer=0.
- Arithmetic: life never wraps below 0. score saturates at 9. level is held at or below LEVEL_MAX.
- If startOfFrame and a PLAY event occur in the same cycle, the event is taken. The timer is reloaded by the new state.

## Structure
- Shared package pinball_pkg holds:
  - the enum round_state_t: IDLE=0, ARM=1, PLAY=2, LOST=3, CLEARED=4, OVER=5;
  - the constants SCORE_MAX=9 and TIMER_W=9.
- Sub-module frame_timer, with ports clk, resetN, load, loadValue[8:0], startOfFrame and expired.

## Test plan
- Reset, then a start rising edge → state ARM after 1 cycle, reset_level_pulse=1 for 1 cycle, life=3, level=1, score=0.
- In ARM, launchKey goes 1 then 0 → PLAY on the cycle after the falling edge, reset_level=0, pause=0.
- In ARM, no key for 301 startOfFrame pulses → autoLaunch pulses once and the state is PLAY.
- In PLAY, ballLost and goodHit in the same cycle → life=2, score=0, state LOST; after 61 frames the state is ARM with a new reset_level_pulse.
- With life=1, badHit → life=0, gameOver=1, won=0. A subsequent start edge → life=3, level=1, state ARM.
- With level=9, goodHit → score+1, won=1, gameOver=1. Assert reset mid-CLEARED countdown → every output at its reset value immediately.

Source files
------------

// File: rtl/pinball_pkg.sv
// rtl/pinball_pkg.sv - shared round states, widths and score helper for the pinball screen
package pinball_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        PLAY    = 3'd2,
        LOST    = 3'd3,
        CLEARED = 3'd4,
        OVER    = 3'd5
    } round_state_t;

    localparam int SCORE_MAX = 9;
    localparam int TIMER_W   = 9;

    function automatic logic [3:0] score_inc(input logic [3:0] v);
        return (v >= 4'(SCORE_MAX)) ? 4'(SCORE_MAX) : v + 4'd1;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - collision/key inputs and round-control outputs of the sequencer
interface round_sequencer_if;

    logic       startOfFrame;
    logic       start;
    logic       launchKey;
    logic       ballLost;
    logic       goodHit;
    logic       badHit;
    logic       pause;
    logic       reset_level;
    logic       reset_level_pulse;
    logic       autoLaunch;
    logic [3:0] life;
    logic [3:0] level;
    logic [3:0] score;
    logic       gameOver;
    logic       won;
    logic [2:0] state;

    modport master (
        output startOfFrame, start, launchKey, ballLost, goodHit, badHit,
        input  pause, reset_level, reset_level_pulse, autoLaunch,
        input  life, level, score, gameOver, won, state
    );

    modport slave (
        input  startOfFrame, start, launchKey, ballLost, goodHit, badHit,
        output pause, reset_level, reset_level_pulse, autoLaunch,
        output life, level, score, gameOver, won, state
    );

endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - frame-paced down counter; expires on the frame boundary seen at count 0
module frame_timer
    import pinball_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic [TIMER_W-1:0] loadValue,
    input  logic               startOfFrame,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = loadValue;
        end else if (startOfFrame && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign expired = startOfFrame && (count_q == '0);

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - ball round FSM: arming, launch, play, loss/clear pauses, game over
module round_sequencer
    import pinball_pkg::*;
#(
    parameter int LIVES_INIT            = 3,
    parameter int LEVEL_MAX             = 9,
    parameter int RESPAWN_FRAMES        = 60,
    parameter int CLEAR_FRAMES          = 90,
    parameter int LAUNCH_TIMEOUT_FRAMES = 300
) (
    input logic              clk,
    input logic              resetN,
    round_sequencer_if.slave bus
);

    round_state_t       state_q, state_d;
    logic [3:0]         life_q, life_d, level_q, level_d, score_q, score_d;
    logic               won_q, won_d, pause_q, pause_d, rl_q, rl_d;
    logic               rlp_q, rlp_d, al_q, al_d, go_q, go_d;
    logic               start_q, start_d, launch_q, launch_d;
    logic               tmr_load, tmr_expired;
    logic [TIMER_W-1:0] tmr_value;
    logic               start_rise, launch_fall, loss;

    frame_timer u_timer (
        .clk          (clk),
        .resetN       (resetN),
        .load         (tmr_load),
        .loadValue    (tmr_value),
        .startOfFrame (bus.startOfFrame),
        .expired      (tmr_expired)
    );

    // Edge copies have no reset so they keep tracking the keys while reset is held.
    always_ff @(posedge clk) begin
        start_q  <= start_d;
        launch_q <= launch_d;
    end

    always_comb begin
        start_d     = bus.start;
        launch_d    = bus.launchKey;
        start_rise  = bus.start && !start_q;
        launch_fall = !bus.launchKey && launch_q;
        loss        = bus.ballLost || bus.badHit;

        state_d   = state_q;
        life_d    = life_q;
        level_d   = level_q;
        score_d   = score_q;
        won_d     = won_q;
        al_d      = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            IDLE, OVER: begin
                if (start_rise) begin
                    life_d  = 4'(LIVES_INIT);
                    level_d = 4'd1;
                    score_d = 4'd0;
                    won_d   = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (launch_fall) begin
                    state_d = PLAY;
                end else if (tmr_expired) begin
                    state_d = PLAY;
                    al_d    = 1'b1;
                end
            end
            PLAY: begin
                if (loss) begin
                    life_d = (life_q != 4'd0) ? life_q - 4'd1 : 4'd0;
                    if (life_d == 4'd0) begin
                        state_d = OVER;
                    end else begin
                        state_d   = LOST;
                        tmr_load  = 1'b1;
                        tmr_value = TIMER_W'(RESPAWN_FRAMES);
                    end
                end else if (bus.goodHit) begin
                    score_d = score_inc(score_q);
                    if (level_q >= 4'(LEVEL_MAX)) begin
                        won_d   = 1'b1;
                        state_d = OVER;
                    end else begin
                        level_d   = level_q + 4'd1;
                        state_d   = CLEARED;
                        tmr_load  = 1'b1;
                        tmr_value = TIMER_W'(CLEAR_FRAMES);
                    end
                end
            end
            LOST, CLEARED: begin
                if (tmr_expired) begin
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every entry to ARM restarts the launch timeout and re-seeds the level.
        rlp_d = (state_d == ARM) && (state_q != ARM);
        if (rlp_d) begin
            tmr_load  = 1'b1;
            tmr_value = TIMER_W'(LAUNCH_TIMEOUT_FRAMES);
        end

        pause_d = !((state_d == ARM) || (state_d == PLAY));
        rl_d    = (state_d != PLAY);
        go_d    = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q <= IDLE;
            life_q  <= 4'(LIVES_INIT);
            level_q <= 4'd1;
            score_q <= 4'd0;
            won_q   <= 1'b0;
            pause_q <= 1'b1;
            rl_q    <= 1'b1;
            rlp_q   <= 1'b0;
            al_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
            level_q <= level_d;
            score_q <= score_d;
            won_q   <= won_d;
            pause_q <= pause_d;
            rl_q    <= rl_d;
            rlp_q   <= rlp_d;
            al_q    <= al_d;
            go_q    <= go_d;
        end
    end

    assign bus.pause             = pause_q;
    assign bus.reset_level       = rl_q;
    assign bus.reset_level_pulse = rlp_q;
    assign bus.autoLaunch        = al_q;
    assign bus.life              = life_q;
    assign bus.level             = level_q;
    assign bus.score             = score_q;
    assign bus.gameOver          = go_q;
    assign bus.won               = won_q;
    assign bus.state             = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - scoreboard bench: expected snapshot per state change, checked by a monitor
module tb_round_sequencer;
    import pinball_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] life;
        logic [3:0] level;
        logic [3:0] score;
        logic       p;
        logic       rl;
        logic       rlp;
        logic       al;
        logic       go;
        logic       won;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    snap_t exp_q[$];

    round_sequencer_if bus ();

    round_sequencer #(
        .LIVES_INIT(3), .LEVEL_MAX(9), .RESPAWN_FRAMES(60),
        .CLEAR_FRAMES(90), .LAUNCH_TIMEOUT_FRAMES(300)
    ) dut (
        .clk    (clk),
        .resetN (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [2:0] st, input int life, input int level, input int score,
                        input logic p, input logic rl, input logic rlp, input logic al,
                        input logic go, input logic won);
        snap_t s;
        s.st = st; s.life = 4'(life); s.level = 4'(level); s.score = 4'(score);
        s.p = p; s.rl = rl; s.rlp = rlp; s.al = al; s.go = go; s.won = won;
        exp_q.push_back(s);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(posedge clk); #1 bus.startOfFrame = 1'b1;
            @(posedge clk); #1 bus.startOfFrame = 1'b0;
        end
    endtask

    task automatic rise_start();
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1 bus.start = 1'b1;
        cycles(2);
    endtask

    task automatic launch();
        @(posedge clk); #1 bus.launchKey = 1'b1;
        @(posedge clk); #1 bus.launchKey = 1'b0;
        cycles(2);
    endtask

    task automatic hit(input logic lost, input logic good, input logic bad);
        @(posedge clk); #1 bus.ballLost = lost; bus.goodHit = good; bus.badHit = bad;
        @(posedge clk); #1 bus.ballLost = 1'b0; bus.goodHit = 1'b0; bus.badHit = 1'b0;
        cycles(1);
    endtask

    // Monitor: every visible state change consumes one expected snapshot.
    initial begin
        logic [2:0] prev_st;
        logic       prev_rlp, prev_al;
        snap_t      cur, e;
        prev_st = 3'h7; prev_rlp = 1'b0; prev_al = 1'b0;
        forever begin
            @(negedge clk);
            cur = {bus.state, bus.life, bus.level, bus.score, bus.pause, bus.reset_level,
                   bus.reset_level_pulse, bus.autoLaunch, bus.gameOver, bus.won};
            if (prev_rlp) begin
                n_cmp++;
                if (bus.reset_level_pulse) begin
                    n_fail++;
                    $display("FAIL rlp_width: got 1 required 0 on second cycle");
                end
            end
            if (prev_al) begin
                n_cmp++;
                if (bus.autoLaunch) begin
                    n_fail++;
                    $display("FAIL autolaunch_width: got 1 required 0 on second cycle");
                end
            end
            if (bus.state != prev_st) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %h with no expectation at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL snapshot st%0d: got %h required %h at %0t", e.st, cur, e, $time);
                    end
                end
            end
            prev_st  = bus.state;
            prev_rlp = bus.reset_level_pulse;
            prev_al  = bus.autoLaunch;
        end
    end

    initial begin
        int k;
        snap_t e;
        bus.startOfFrame = 1'b0; bus.start = 1'b0; bus.launchKey = 1'b0;
        bus.ballLost = 1'b0; bus.goodHit = 1'b0; bus.badHit = 1'b0;

        push(IDLE, 3, 1, 0, 1, 1, 0, 0, 0, 0);
        cycles(3);
        rst = 1'b0;

        push(ARM, 3, 1, 0, 0, 1, 1, 0, 0, 0);
        rise_start();
        push(PLAY, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        launch();

        push(LOST, 2, 1, 0, 1, 1, 0, 0, 0, 0);
        hit(1'b1, 1'b1, 1'b0);
        hit(1'b0, 1'b1, 1'b0);
        frames(60);
        cycles(3);
        push(ARM, 2, 1, 0, 0, 1, 1, 0, 0, 0);
        frames(1);

        frames(300);
        cycles(3);
        push(PLAY, 2, 1, 0, 0, 0, 0, 1, 0, 0);
        frames(1);

        push(CLEARED, 2, 2, 1, 1, 1, 0, 0, 0, 0);
        hit(1'b0, 1'b1, 1'b0);
        frames(90);
        cycles(3);
        push(ARM, 2, 2, 1, 0, 1, 1, 0, 0, 0);
        frames(1);

        push(PLAY, 2, 2, 1, 0, 0, 0, 0, 0, 0);
        launch();
        push(LOST, 1, 2, 1, 1, 1, 0, 0, 0, 0);
        hit(1'b0, 1'b0, 1'b1);
        push(ARM, 1, 2, 1, 0, 1, 1, 0, 0, 0);
        frames(61);
        push(PLAY, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        launch();
        push(OVER, 0, 2, 1, 1, 1, 0, 0, 1, 0);
        hit(1'b1, 1'b0, 1'b1);

        push(ARM, 3, 1, 0, 0, 1, 1, 0, 0, 0);
        rise_start();
        for (int i = 0; i < 8; i++) begin
            push(PLAY, 3, i + 1, i, 0, 0, 0, 0, 0, 0);
            launch();
            push(CLEARED, 3, i + 2, i + 1, 1, 1, 0, 0, 0, 0);
            hit(1'b0, 1'b1, 1'b0);
            push(ARM, 3, i + 2, i + 1, 0, 1, 1, 0, 0, 0);
            frames(91);
        end
        push(PLAY, 3, 9, 8, 0, 0, 0, 0, 0, 0);
        launch();
        push(OVER, 3, 9, 9, 1, 1, 0, 0, 1, 1);
        hit(1'b0, 1'b1, 1'b0);

        push(ARM, 3, 1, 0, 0, 1, 1, 0, 0, 0);
        rise_start();
        push(PLAY, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        launch();
        push(CLEARED, 3, 2, 1, 1, 1, 0, 0, 0, 0);
        hit(1'b0, 1'b1, 1'b0);
        frames(20);
        push(IDLE, 3, 1, 0, 1, 1, 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        #2 rst = 1'b0;
        cycles(4);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no state change seen, required %h", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
